// File: rtl/alu_ctrl_pkg.sv
// Shared types, opcode/flag constants and decode helpers for the ALU request arbiter.
package alu_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, RESPOND} state_t;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_XOR = 4'd2;
    localparam logic [3:0] OP_SHL = 4'd3;
    localparam logic [3:0] OP_SHR = 4'd4;
    localparam logic [3:0] OP_MOD = 4'd5;
    localparam logic [3:0] OP_ADD = 4'd6;
    localparam logic [3:0] OP_SUB = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_DIV = 4'd9;
    localparam logic [3:0] OP_CLR = 4'd15;

    localparam int F_C = 3;
    localparam int F_V = 2;
    localparam int F_N = 1;
    localparam int F_Z = 0;

    // Unassigned opcodes 10..14, or mod/div with a zero divisor.
    function automatic logic op_is_err(input logic [3:0] op, input logic b_zero);
        return ((op >= 4'd10) && (op <= 4'd14)) || (((op == OP_MOD) || (op == OP_DIV)) && b_zero);
    endfunction

    function automatic logic [3:0] flag_mask(input logic [3:0] op, input logic [3:0] f);
        logic [3:0] m;
        m      = '0;
        m[F_Z] = f[F_Z];
        m[F_C] = (op == OP_ADD) & f[F_C];
        m[F_N] = (op == OP_SUB) & f[F_N];
        m[F_V] = ((op == OP_ADD) || (op == OP_SUB)) & f[F_V];
        if (op == OP_CLR) m = '0;
        return m;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       any
);
    localparam int IW = $clog2(NUM_REQ);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int j;
            j = int'(ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin sequencer sharing one combinational ALU among NUM_REQ requesters.
// Optional per-requester statistics counters are enabled by defining ALU_ARB_STATS_EN.
module alu_req_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int N       = 4,
    parameter int NUM_REQ = 2,
    parameter int ALU_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*N-1:0]       req_a,
    input  logic [NUM_REQ*N-1:0]       req_b,
    input  logic [NUM_REQ*4-1:0]       req_op,
    output logic [N-1:0]               alu_a,
    output logic [N-1:0]               alu_b,
    output logic [3:0]                 alu_op,
    input  logic [N-1:0]               alu_y,
    input  logic [N-1:0]               alu_x,
    input  logic [N-1:0]               alu_z,
    input  logic [N-1:0]               alu_w,
    input  logic [3:0]                 alu_flags,
    output logic [NUM_REQ-1:0]         rsp_valid,
    input  logic [NUM_REQ-1:0]         rsp_ready,
    output logic [N-1:0]               rsp_y,
    output logic [N-1:0]               rsp_x,
    output logic [N-1:0]               rsp_z,
    output logic [N-1:0]               rsp_w,
    output logic [3:0]                 rsp_flags,
    output logic                       rsp_err,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]      op_count,
    output logic [7:0]                 err_count
`endif
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [IW-1:0]  rr_ptr;

    logic [NUM_REQ-1:0] gnt;
    logic [IW-1:0]      gidx;
    logic               gany;
    logic [N-1:0]       sel_a, sel_b;
    logic [3:0]         sel_op;
    logic               accept, hs;
    logic [IW-1:0]      next_ptr;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (gnt),
        .idx   (gidx),
        .any   (gany)
    );

    assign sel_a    = req_a[int'(gidx)*N +: N];
    assign sel_b    = req_b[int'(gidx)*N +: N];
    assign sel_op   = req_op[int'(gidx)*4 +: 4];
    assign accept   = (state == IDLE) && gany;
    // Held low while reset is asserted so no accept pulse escapes during reset.
    assign req_ready = ((state == IDLE) && rst_n) ? gnt : '0;
    assign hs       = |(rsp_valid & rsp_ready);
    assign busy     = (state != IDLE);
    assign next_ptr = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rr_ptr    <= '0;
            grant_id  <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            rsp_valid <= '0;
            rsp_y     <= '0;
            rsp_x     <= '0;
            rsp_z     <= '0;
            rsp_w     <= '0;
            rsp_flags <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        grant_id <= gidx;
                        if (op_is_err(sel_op, sel_b == '0)) begin
                            // Rejected without touching the ALU inputs.
                            state     <= RESPOND;
                            rsp_valid <= gnt;
                            rsp_err   <= 1'b1;
                            rsp_y     <= '0;
                            rsp_x     <= '0;
                            rsp_z     <= '0;
                            rsp_w     <= '0;
                            rsp_flags <= '0;
                        end else begin
                            state  <= ISSUE;
                            cnt    <= CW'(ALU_LAT - 1);
                            alu_a  <= sel_a;
                            alu_b  <= sel_b;
                            alu_op <= sel_op;
                        end
                    end
                end
                ISSUE: begin
                    if (cnt == '0) begin
                        state     <= RESPOND;
                        rsp_valid <= ONE_HOT0 << grant_id;
                        rsp_err   <= 1'b0;
                        rsp_flags <= flag_mask(alu_op, alu_flags);
                        if (alu_op == OP_CLR) begin
                            rsp_y <= '0;
                            rsp_x <= '0;
                            rsp_z <= '0;
                            rsp_w <= '0;
                        end else begin
                            rsp_y <= alu_y;
                            rsp_x <= alu_x;
                            rsp_z <= alu_z;
                            rsp_w <= alu_w;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESPOND: begin
                    if (hs) begin
                        rsp_valid <= '0;
                        rr_ptr    <= next_ptr;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count  <= '0;
            err_count <= '0;
        end else if (hs) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if ((int'(grant_id) == i) && (op_count[i*16 +: 16] != 16'hFFFF)) begin
                    op_count[i*16 +: 16] <= op_count[i*16 +: 16] + 16'd1;
                end
            end
            if (rsp_err && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter: one ALU_LAT=1 instance and one ALU_LAT=3 instance.
module tb_alu_req_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference ALU: raw flags deliberately set C/V on logic ops so masking is visible.
    function automatic logic [19:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                              input logic [3:0] op);
        logic [3:0] y, x;
        logic       c, v;
        logic [4:0] s;
        logic [7:0] p;
        y = 4'd0; x = 4'd0; c = 1'b1; v = 1'b1; s = 5'd0; p = 8'd0;
        case (op)
            4'd0: y = a & b;
            4'd1: y = a | b;
            4'd2: y = a ^ b;
            4'd3: y = a << 1;
            4'd4: y = a >> 1;
            4'd5: y = (b != 4'd0) ? a % b : 4'd0;
            4'd6: begin
                s = {1'b0, a} + {1'b0, b};
                y = s[3:0]; c = s[4]; v = (a[3] == b[3]) && (y[3] != a[3]);
            end
            4'd7: begin
                s = {1'b0, a} - {1'b0, b};
                y = s[3:0]; c = s[4]; v = (a[3] != b[3]) && (y[3] != a[3]);
            end
            4'd8: begin
                p = {4'd0, a} * {4'd0, b};
                y = p[3:0]; x = p[7:4];
            end
            4'd9: begin
                y = (b != 4'd0) ? a / b : 4'd0;
                x = (b != 4'd0) ? a % b : 4'd0;
            end
            default: y = a;
        endcase
        return {y, x, ~a, ~b, c, v, y[3], (y == 4'd0)};
    endfunction

    // Instance 1: ALU_LAT = 1
    logic       rst_n;
    logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
    logic [7:0] req_a, req_b, req_op;
    logic [3:0] alu_a, alu_b, alu_op, alu_y, alu_x, alu_z, alu_w, alu_flags;
    logic [3:0] rsp_y, rsp_x, rsp_z, rsp_w, rsp_flags;
    logic       rsp_err, busy, grant_id;
`ifdef ALU_ARB_STATS_EN
    logic [31:0] op_count;
    logic [7:0]  err_count;
`endif
    assign {alu_y, alu_x, alu_z, alu_w, alu_flags} = alu_model(alu_a, alu_b, alu_op);

    alu_req_arbiter #(.N(4), .NUM_REQ(2), .ALU_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_y(alu_y), .alu_x(alu_x), .alu_z(alu_z), .alu_w(alu_w), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y), .rsp_x(rsp_x), .rsp_z(rsp_z), .rsp_w(rsp_w),
        .rsp_flags(rsp_flags), .rsp_err(rsp_err), .busy(busy), .grant_id(grant_id)
`ifdef ALU_ARB_STATS_EN
        , .op_count(op_count), .err_count(err_count)
`endif
    );

    // Instance 2: ALU_LAT = 3
    logic       rst_n3;
    logic [1:0] req_valid3, req_ready3, rsp_valid3, rsp_ready3;
    logic [7:0] req_a3, req_b3, req_op3;
    logic [3:0] alu_a3, alu_b3, alu_op3, alu_y3, alu_x3, alu_z3, alu_w3, alu_flags3;
    logic [3:0] rsp_y3, rsp_x3, rsp_z3, rsp_w3, rsp_flags3;
    logic       rsp_err3, busy3, grant_id3;
`ifdef ALU_ARB_STATS_EN
    logic [31:0] op_count3;
    logic [7:0]  err_count3;
`endif
    assign {alu_y3, alu_x3, alu_z3, alu_w3, alu_flags3} = alu_model(alu_a3, alu_b3, alu_op3);

    alu_req_arbiter #(.N(4), .NUM_REQ(2), .ALU_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n3), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_a(req_a3), .req_b(req_b3), .req_op(req_op3),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3),
        .alu_y(alu_y3), .alu_x(alu_x3), .alu_z(alu_z3), .alu_w(alu_w3), .alu_flags(alu_flags3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_y(rsp_y3), .rsp_x(rsp_x3), .rsp_z(rsp_z3), .rsp_w(rsp_w3),
        .rsp_flags(rsp_flags3), .rsp_err(rsp_err3), .busy(busy3), .grant_id(grant_id3)
`ifdef ALU_ARB_STATS_EN
        , .op_count(op_count3), .err_count(err_count3)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; rst_n3 = 1'b0;
        req_valid = 2'b01; rsp_ready = '0; req_a = '0; req_b = '0; req_op = '0;
        req_valid3 = '0; rsp_ready3 = '0; req_a3 = '0; req_b3 = '0; req_op3 = '0;

        // Reset state
        tick();
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_alu_op", alu_op, 4'h0);
        chk("rst_grant_id", grant_id, 1'b0);
        chk("rst_rsp_flags", rsp_flags, 4'h0);
        req_valid = 2'b00;
        rst_n = 1'b1; rst_n3 = 1'b1;
        tick();

        // Add 7+9 from req0: carry out, zero result
        req_a = 8'h07; req_b = 8'h09; req_op = 8'h06; req_valid = 2'b01;
        #1 chk("t1_req_ready", req_ready, 2'b01);
        tick(); req_valid = 2'b00; #1;
        chk("t1_busy", busy, 1'b1);
        chk("t1_alu_a", alu_a, 4'h7);
        chk("t1_alu_b", alu_b, 4'h9);
        chk("t1_alu_op", alu_op, 4'h6);
        chk("t1_rsp_valid_early", rsp_valid, 2'b00);
        tick();
        chk("t1_rsp_valid", rsp_valid, 2'b01);
        chk("t1_rsp_y", rsp_y, 4'h0);
        chk("t1_rsp_z", rsp_z, 4'h8);
        chk("t1_rsp_w", rsp_w, 4'h6);
        chk("t1_rsp_flags", rsp_flags, 4'b1001);
        chk("t1_rsp_err", rsp_err, 1'b0);
        rsp_ready = 2'b01;
        tick(); rsp_ready = 2'b00;
        chk("t1_rsp_valid_drop", rsp_valid, 2'b00);
        chk("t1_busy_drop", busy, 1'b0);
        chk("t1_flags_kept", rsp_flags, 4'b1001);

        // Divide by zero from req1 (rr_ptr now 1)
        req_a = 8'hD0; req_b = 8'h00; req_op = 8'h90; req_valid = 2'b10;
        #1 chk("t3_req_ready", req_ready, 2'b10);
        tick(); req_valid = 2'b00;
        chk("t3_rsp_valid", rsp_valid, 2'b10);
        chk("t3_rsp_err", rsp_err, 1'b1);
        chk("t3_rsp_words", {rsp_y, rsp_x, rsp_z, rsp_w}, 16'h0000);
        chk("t3_rsp_flags", rsp_flags, 4'h0);
        chk("t3_alu_held", {alu_a, alu_b, alu_op}, 12'h796);
        chk("t3_grant_id", grant_id, 1'b1);
        rsp_ready = 2'b01;
        tick();
        chk("t3_non_owner_ignored", rsp_valid, 2'b10);
        rsp_ready = 2'b10;
        tick(); rsp_ready = 2'b00;
        chk("t3_done", rsp_valid, 2'b00);
        chk("t3_err_kept", rsp_err, 1'b1);

        // Both requesters valid, rr_ptr back to 0: expect grants 0, 1, 0
        req_a = 8'h3C; req_b = 8'h5A; req_op = 8'h00; req_valid = 2'b11;
        #1 chk("t2_ready_g0", req_ready, 2'b01);
        tick();
        chk("t2_no_grant_busy", req_ready, 2'b00);
        chk("t2_gid0", grant_id, 1'b0);
        tick();
        chk("t2_rsp_valid_g0", rsp_valid, 2'b01);
        chk("t2_rsp_y_g0", rsp_y, 4'h8);
        chk("t2_flags_masked", rsp_flags, 4'h0);
        chk("t2_rsp_zw_g0", {rsp_z, rsp_w}, 8'h35);
        rsp_ready = 2'b11;
        tick();
        chk("t2_idle_gap", rsp_valid, 2'b00);
        chk("t2_ready_g1", req_ready, 2'b10);
        tick();
        chk("t2_gid1", grant_id, 1'b1);
        tick();
        chk("t2_rsp_valid_g1", rsp_valid, 2'b10);
        chk("t2_rsp_y_g1", rsp_y, 4'h1);
        tick();
        chk("t2_ready_g0_again", req_ready, 2'b01);
        tick(); req_valid = 2'b00;
        chk("t2_gid0_again", grant_id, 1'b0);
        tick();
        chk("t2_rsp_valid_g0_again", rsp_valid, 2'b01);
        tick(); rsp_ready = 2'b00;
        chk("t2_done", busy, 1'b0);

        // Sub 2-5 from req1 with response back-pressure
        req_a = 8'h20; req_b = 8'h50; req_op = 8'h70; req_valid = 2'b10;
        tick(); req_valid = 2'b00;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", rsp_valid, 2'b10);
            chk("t4_hold_data", {rsp_y, rsp_x, rsp_z, rsp_w}, 16'hD0DA);
            chk("t4_hold_flags", rsp_flags, 4'b0010);
            tick();
        end
        rsp_ready = 2'b10;
        tick(); rsp_ready = 2'b00;
        chk("t4_done", rsp_valid, 2'b00);
        chk("t4_y_kept", rsp_y, 4'hD);

        // Clear op from req0 forces zero results and flags
        req_a = 8'h05; req_b = 8'h03; req_op = 8'h0F; req_valid = 2'b01;
        tick(); req_valid = 2'b00;
        chk("clr_alu_op", alu_op, 4'hF);
        tick();
        chk("clr_rsp_valid", rsp_valid, 2'b01);
        chk("clr_rsp_words", {rsp_y, rsp_x, rsp_z, rsp_w}, 16'h0000);
        chk("clr_rsp_flags_err", {rsp_flags, rsp_err}, 5'b00000);
        rsp_ready = 2'b01;
        tick(); rsp_ready = 2'b00;

        // ALU_LAT=3: reset during ISSUE aborts, then a normal op
        req_a3 = 8'h01; req_b3 = 8'h02; req_op3 = 8'h06; req_valid3 = 2'b01;
        tick(); req_valid3 = 2'b00;
        chk("l3_busy", busy3, 1'b1);
        chk("l3_alu_a", alu_a3, 4'h1);
        tick();
        rst_n3 = 1'b0; #1;
        chk("l3_rst_busy", busy3, 1'b0);
        chk("l3_rst_alu", {alu_a3, alu_b3, alu_op3}, 12'h000);
        chk("l3_rst_rsp_valid", rsp_valid3, 2'b00);
        tick(); tick();
        chk("l3_rst_no_rsp", rsp_valid3, 2'b00);
        rst_n3 = 1'b1;
        tick();
        chk("l3_post_rst_idle", {busy3, rsp_valid3}, 3'b000);
        req_a3 = 8'h05; req_b3 = 8'h03; req_op3 = 8'h06; req_valid3 = 2'b01;
        tick(); req_valid3 = 2'b00;
        chk("l3_lat_e0", rsp_valid3, 2'b00);
        tick();
        chk("l3_lat_e1", rsp_valid3, 2'b00);
        tick();
        chk("l3_lat_e2", rsp_valid3, 2'b00);
        tick();
        chk("l3_lat_e3", rsp_valid3, 2'b01);
        chk("l3_rsp_words", {rsp_y3, rsp_x3, rsp_z3, rsp_w3}, 16'h80AC);
        chk("l3_rsp_flags", rsp_flags3, 4'b0100);
        rsp_ready3 = 2'b01;
        tick(); rsp_ready3 = 2'b00;
        chk("l3_done", rsp_valid3, 2'b00);

`ifdef ALU_ARB_STATS_EN
        chk("stats_op_count", op_count, {16'd3, 16'd4});
        chk("stats_err_count", err_count, 8'd1);
        chk("stats3_op_count", op_count3, {16'd0, 16'd1});
        chk("stats3_err_count", err_count3, 8'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
Sequencer and arbiter that shares one combinational ALU datapath (AND/OR/XOR/shifts/mod/add/sub/mul/div, 4-bit opcode) among NUM_REQ requesters, e.g. the switch panel and a test/UART port.
- Grants requesters round-robin and registers the granted operands and opcode onto the ALU inputs.
- Waits a fixed settle latency, then captures the result words and flags.
- Returns them over a valid/ready response handshake.
- Sits between the requesters and the alu instance in the lab-3 top level.

Parameters:
- N, 4, operand/result word width.
- NUM_REQ, 2, number of requesters (2..4).
- ALU_LAT, 1, cycles the ALU inputs are held before capture (>=1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  request pending, one bit per requester
- req_ready  out  NUM_REQ  one-cycle accept pulse to the granted requester
- req_a  in  NUM_REQ*N  operand A per requester (requester i at [i*N +: N])
- req_b  in  NUM_REQ*N  operand B per requester
- req_op  in  NUM_REQ*4  opcode per requester
- alu_a, alu_b  out  N  registered ALU operands
- alu_op  out  4  registered ALU opcode
- alu_y, alu_x, alu_z, alu_w  in  N  ALU result words
- alu_flags  in  4  {carry, overflow, negative, zero} from the ALU
- rsp_valid  out  NUM_REQ  response valid, one-hot to the owner
- rsp_ready  in  NUM_REQ  response accepted
- rsp_y, rsp_x, rsp_z, rsp_w  out  N  captured results, broadcast to all requesters
- rsp_flags  out  4  masked flags {C,V,N,Z}
- rsp_err  out  1  illegal opcode or divide/mod by zero
- busy  out  1  state != IDLE
- grant_id  out  $clog2(NUM_REQ)  current or last owner

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr_ptr=0.
  - All outputs are 0, including req_ready, rsp_valid, alu_*, rsp_*, grant_id and busy.
  - Reset mid-operation aborts the operation; no rsp_valid is produced for it.
- States are IDLE, ISSUE, RESPOND.
- IDLE:
  - If any req_valid is set, grant the first set bit searching from rr_ptr upward with wrap.
  - Pulse req_ready[g] for that cycle; acceptance is req_valid[g]&req_ready[g].
  - At the acceptance edge, latch a/b/op into alu_a/alu_b/alu_op and set grant_id=g.
  - Legal opcode, nonzero divisor: go to ISSUE with cnt=ALU_LAT-1.
  - Error cases (opcode 1010..1110; op 0101 or 1001 with b==0):
    - go straight to RESPOND;
    - rsp_err=1, results=0, flags=0;
    - alu_* are not updated.
- ISSUE:
  - alu_a, alu_b and alu_op are held stable.
  - At cnt==0, capture alu_y/x/z/w into rsp_*, apply the flag mask and go to RESPOND. Otherwise cnt decrements.
  - rsp_valid rises exactly ALU_LAT cycles after the acceptance edge.
- Flag mask:
  - Z is always passed.
  - C is passed only for op 0110.
  - N is passed only for op 0111.
  - V is passed only for 0110/0111.
  - All other flags read 0.
- Op 1111 (clear): legal. Results and flags are forced to 0 regardless of ALU inputs; rsp_err=0.
- RESPOND:
  - rsp_valid[g] is held with stable data until rsp_ready[g].
  - On that edge: rsp_valid=0, rr_ptr=(g+1) mod NUM_REQ, state goes to IDLE. rsp_* retain their values.
  - rsp_ready on non-owner bits is ignored.
- Throughput: at least one IDLE cycle between operations; no new grant is made while busy.
- A requester may deassert req_valid before it is granted without error.
- Simultaneous requests are resolved strictly by rr_ptr; a requester that is continuously valid waits at most NUM_REQ-1 operations.

Optional Feature:
- Macro ALU_ARB_STATS_EN.
- When defined:
  - adds output op_count, NUM_REQ*16 bits: per-requester saturating counters (stop at 16'hFFFF);
  - a counter increments on each response handshake for that requester;
  - adds output err_count, 8 bits, saturating, counting rsp_err handshakes;
  - all counters reset to 0.
- When undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Package alu_ctrl_pkg:
  - state enum {IDLE, ISSUE, RESPOND};
  - opcode constants OP_AND=0, OP_OR=1, OP_XOR=2, OP_SHL=3, OP_SHR=4, OP_MOD=5, OP_ADD=6, OP_SUB=7, OP_MUL=8, OP_DIV=9, OP_CLR=15;
  - flag index constants F_C=3, F_V=2, F_N=1, F_Z=0.
- Sub-module rr_arbiter (NUM_REQ param; inputs req and ptr; outputs one-hot grant, index and any).

Test Plan:
- Single request from req0, op=6, a=4'h7, b=4'h9, ALU_LAT=1 -> req_ready pulse; rsp_valid[0] one cycle after acceptance; rsp_y=4'h0, flags C=1, Z=1, N=0.
- req0 and req1 valid together with rr_ptr=0, both op=0 -> grants in order 0, then 1, then 0; each rsp_valid appears only on the owner's bit.
- req1, op=9, a=4'hD, b=4'h0 -> no ALU issue; rsp_err=1 and all results 0 in RESPOND; alu_* unchanged.
- op=7, a=2, b=5, then rsp_ready held low for 5 cycles -> rsp_valid and data stable throughout; N flag passed; C=0.
- rst_n pulsed low during ISSUE with ALU_LAT=3 -> all outputs 0 immediately; no rsp_valid; the next request completes normally.
- ALU_ARB_STATS_EN defined, 3 ops from req0 and 1 error from req1 -> op_count[0]=3, op_count[1]=1, err_count=1.
